// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - instruction fetch front end with redirect flush and stale-response drop
// Optional FETCH_PERF_EN adds perf_redirect_cnt / perf_drop_cnt outputs.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flow_change,
  input  logic [31:0] br_addr,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_redirect_cnt,
  output logic [31:0] perf_drop_cnt
`endif
);

  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;
  localparam int UW = CW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] q_cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   q_pc    [FQ_DEPTH];
  logic [31:0]   q_instr [FQ_DEPTH];

  logic [UW-1:0] used;
  logic [31:0]   redirect_pc;
  logic          req_fire;
  logic          rsp_ok;
  logic          push;
  logic          pop;
  logic          drop_evt;

  // Credit covers both in-flight requests and queued entries, so a push never finds the queue full.
  assign used           = {1'b0, out_cnt} + {1'b0, q_cnt};
  assign imem_req_valid = rst_n && !flow_change && (used < UW'(FQ_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol violation and is ignored outright.
  assign rsp_ok      = imem_rsp_valid && (out_cnt != '0);
  assign drop_evt    = rsp_ok && (flow_change || (drop_cnt != '0));
  assign push        = rsp_ok && !flow_change && (drop_cnt == '0);
  assign redirect_pc = {br_addr[31:2], 2'b00};

  assign if_valid = (q_cnt != '0) && !flow_change;
  assign if_pc    = q_pc[rd_ptr];
  assign if_instr = q_instr[rd_ptr];
  assign pop      = if_valid && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
      q_cnt    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      out_cnt <= out_cnt + CW'(req_fire) - CW'(rsp_ok);
      if (flow_change) begin
        // Every request still in flight after this cycle belongs to the old path.
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop_cnt <= out_cnt - CW'(rsp_ok);
        q_cnt    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (rsp_ok && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - 1'b1;
        end
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        q_cnt <= q_cnt + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        q_pc[i]    <= RESET_PC;
        q_instr[i] <= '0;
      end
    end else if (push) begin
      q_pc[wr_ptr]    <= rsp_pc;
      q_instr[wr_ptr] <= imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_redirect_cnt <= '0;
      perf_drop_cnt     <= '0;
    end else begin
      perf_redirect_cnt <= perf_redirect_cnt + 32'(flow_change);
      perf_drop_cnt     <= perf_drop_cnt + 32'(drop_evt);
    end
  end
`endif

endmodule
